// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and frame bit values.
// Both uart_tx and uart_rx import this package.
package uart_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE     = 2'b00,
    STATE_TX_START = 2'b01,
    STATE_TX_DATA  = 2'b10,
    STATE_TX_STOP  = 2'b11
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: strikes on the last clk of each bit period while enabled.
// The sync clear realigns the period to a frame acceptance.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic strike
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_p0;

  assign strike = en && (cnt_p0 == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_p0 <= '0;
    end else if (clr) begin
      cnt_p0 <= '0;
    end else if (en) begin
      if (cnt_p0 == LAST) cnt_p0 <= '0;
      else                cnt_p0 <= cnt_p0 + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: serialises one word per accepted send as start, LSB-first
// data and stop bits, with tx/busy/send_finish all driven from flops.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in,
  input  logic       send,
  output logic       tx,
  output logic       busy,
  output logic       send_finish
);

  localparam int BIT_W = $clog2(DATA_BITS);

  state_t               state_p0, state_nxt;
  logic [DATA_BITS-1:0] shift_p0, shift_nxt;
  logic [BIT_W-1:0]     bit_cnt_p0, bit_cnt_nxt;
  logic                 tx_nxt, busy_nxt, fin_nxt;
  logic                 accept, strike;

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .en     (state_p0 != STATE_IDLE),
    .strike (strike)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_p0    <= STATE_IDLE;
      shift_p0    <= '0;
      bit_cnt_p0  <= '0;
      tx          <= STOP_BIT;
      busy        <= 1'b0;
      send_finish <= 1'b0;
    end else begin
      state_p0    <= state_nxt;
      shift_p0    <= shift_nxt;
      bit_cnt_p0  <= bit_cnt_nxt;
      tx          <= tx_nxt;
      busy        <= busy_nxt;
      send_finish <= fin_nxt;
    end
  end

  // tx is registered, so each branch sets the line value for the upcoming bit.
  always_comb begin
    state_nxt   = state_p0;
    shift_nxt   = shift_p0;
    bit_cnt_nxt = bit_cnt_p0;
    tx_nxt      = tx;
    busy_nxt    = busy;
    fin_nxt     = 1'b0;
    accept      = 1'b0;
    case (state_p0)
      STATE_IDLE: begin
        tx_nxt   = STOP_BIT;
        busy_nxt = 1'b0;
        if (send) begin
          accept      = 1'b1;
          state_nxt   = STATE_TX_START;
          shift_nxt   = in[DATA_BITS-1:0];
          bit_cnt_nxt = '0;
          tx_nxt      = START_BIT;
          busy_nxt    = 1'b1;
        end
      end
      STATE_TX_START: begin
        if (strike) begin
          state_nxt = STATE_TX_DATA;
          tx_nxt    = shift_p0[0];
        end
      end
      STATE_TX_DATA: begin
        if (strike) begin
          shift_nxt = shift_p0 >> 1;
          if (bit_cnt_p0 == BIT_W'(DATA_BITS - 1)) begin
            bit_cnt_nxt = '0;
            state_nxt   = STATE_TX_STOP;
            tx_nxt      = STOP_BIT;
          end else begin
            bit_cnt_nxt = bit_cnt_p0 + BIT_W'(1);
            tx_nxt      = shift_p0[1];
          end
        end
      end
      STATE_TX_STOP: begin
        if (strike) begin
          if (bit_cnt_p0 == BIT_W'(STOP_BITS - 1)) begin
            bit_cnt_nxt = '0;
            state_nxt   = STATE_IDLE;
            tx_nxt      = STOP_BIT;
            busy_nxt    = 1'b0;
            fin_nxt     = 1'b1;
          end else begin
            bit_cnt_nxt = bit_cnt_p0 + BIT_W'(1);
          end
        end
      end
      default: begin
        state_nxt = STATE_IDLE;
        tx_nxt    = STOP_BIT;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at default parameters (2 clks/bit, 8N1).
module tb_uart_tx;

  localparam int CPB = 2;
  localparam int FRAME = 10 * CPB;

  logic       clk;
  logic       rst;
  logic [7:0] in;
  logic       send;
  logic       tx;
  logic       busy;
  logic       send_finish;

  int checks = 0;
  int passes = 0;

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .in          (in),
    .send        (send),
    .tx          (tx),
    .busy        (busy),
    .send_finish (send_finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // Called one step after the acceptance edge; walks the whole frame and
  // ends in the send_finish cycle. poke_k >= 0 pulses send with poke_v mid-frame.
  task automatic expect_frame(input logic [7:0] b, input string tag,
                              input int poke_k, input logic [7:0] poke_v);
    logic [9:0] bits;
    logic [7:0] rx;
    bits = {1'b1, b, 1'b0};
    rx = 8'h00;
    for (int k = 0; k < FRAME; k++) begin
      if (poke_k >= 0 && k == poke_k) begin
        send = 1'b1;
        in   = poke_v;
      end else if (poke_k >= 0 && k == poke_k + 1) begin
        send = 1'b0;
      end
      chk({tag, ".tx"}, {31'd0, tx}, {31'd0, bits[k / CPB]});
      chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
      chk({tag, ".fin_lo"}, {31'd0, send_finish}, 32'd0);
      if ((k % CPB) == 0 && k >= CPB && k < 9 * CPB) rx[k / CPB - 1] = tx;
      tick();
    end
    chk({tag, ".rx_word"}, {24'd0, rx}, {24'd0, b});
    chk({tag, ".end_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, ".end_fin"}, {31'd0, send_finish}, 32'd1);
    chk({tag, ".end_tx"}, {31'd0, tx}, 32'd1);
  endtask

  task automatic start_frame(input logic [7:0] b);
    in   = b;
    send = 1'b1;
    tick();
    send = 1'b0;
  endtask

  initial begin
    rst  = 1'b0;
    send = 1'b1;
    in   = 8'hFF;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst.tx", {31'd0, tx}, 32'd1);
      chk("rst.busy", {31'd0, busy}, 32'd0);
      chk("rst.fin", {31'd0, send_finish}, 32'd0);
    end
    send = 1'b0;
    rst  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst.idle_tx", {31'd0, tx}, 32'd1);
      chk("post_rst.idle_busy", {31'd0, busy}, 32'd0);
    end

    // Single frame, A5
    start_frame(8'hA5);
    expect_frame(8'hA5, "a5", -10, 8'h00);
    tick();
    chk("a5.fin_one_cycle", {31'd0, send_finish}, 32'd0);
    chk("a5.idle_busy", {31'd0, busy}, 32'd0);

    // Word patterns
    start_frame(8'h00);
    expect_frame(8'h00, "w00", -10, 8'h00);
    tick();
    start_frame(8'hFF);
    expect_frame(8'hFF, "wff", -10, 8'h00);
    tick();
    start_frame(8'h3C);
    expect_frame(8'h3C, "w3c", -10, 8'h00);
    tick();

    // Send while busy is dropped
    start_frame(8'h81);
    expect_frame(8'h81, "busy_ign", 6, 8'h7E);
    for (int i = 0; i < 3 * CPB; i++) begin
      tick();
      chk("busy_ign.no_2nd_tx", {31'd0, tx}, 32'd1);
      chk("busy_ign.no_2nd_busy", {31'd0, busy}, 32'd0);
    end

    // Back-to-back with send held high; in changes after acceptance
    in   = 8'h55;
    send = 1'b1;
    tick();
    in = 8'hAA;
    expect_frame(8'h55, "b2b_1", -10, 8'h00);
    tick();
    chk("b2b.restart_tx", {31'd0, tx}, 32'd0);
    chk("b2b.restart_busy", {31'd0, busy}, 32'd1);
    in = 8'h0F;
    send = 1'b0;
    expect_frame(8'hAA, "b2b_2", -10, 8'h00);
    tick();
    chk("b2b.stopped", {31'd0, busy}, 32'd0);

    // Reset during data bit 3 of C3 (bit 3 = 0)
    start_frame(8'hC3);
    for (int i = 0; i < 4 * CPB; i++) tick();
    chk("midrst.pre_tx", {31'd0, tx}, 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst.async_tx", {31'd0, tx}, 32'd1);
    chk("midrst.async_busy", {31'd0, busy}, 32'd0);
    chk("midrst.async_fin", {31'd0, send_finish}, 32'd0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      chk("midrst.quiet_tx", {31'd0, tx}, 32'd1);
      chk("midrst.quiet_fin", {31'd0, send_finish}, 32'd0);
    end
    start_frame(8'h12);
    expect_frame(8'h12, "after_rst", -10, 8'h00);
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
